harris_corner_collector: RTL and testbench

- Downstream reader of the Harris corner detector. Consumes the per-pixel corner_detected flag and the corner coordinate stream.
- Suppresses repeated reports of the same coordinate and buffers unique corners in a FIFO. Presents them on a valid/ready stream to the HPS-side reader.
- At each frame boundary (falling edge of VGA_VS) commits per-frame statistics: corner count, bounding box and overflow flag.

---
 rtl/harris_corner_collector_pkg.sv | 17 +
 rtl/harris_corner_collector_corner_fifo.sv | 64 ++++++
 rtl/harris_corner_collector.sv | 202 ++++++++++++++++++++
 tb/tb_harris_corner_collector.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harris_corner_collector_pkg.sv
// rtl/harris_corner_collector_pkg.sv - shared vision constants and types for the corner collector
package harris_corner_collector_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int VGA_WIDTH  = 640;
    localparam int VGA_HEIGHT = 480;
    localparam logic [DEF_ADDR_W-1:0] COORD_ALL_ONES = '1;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] x;
        logic [DEF_ADDR_W-1:0] y;
    } corner_t;

    typedef enum logic {
        WAIT_VS = 1'b0,
        ACTIVE  = 1'b1
    } state_t;
endpackage

// File: rtl/harris_corner_collector_corner_fifo.sv
// rtl/harris_corner_collector_corner_fifo.sv - synchronous corner FIFO with a registered head
module harris_corner_collector_corner_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 20,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_ready,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output logic [LVL_W-1:0]  level,
    output logic              full
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              head_valid_q, head_valid_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              pop;
    logic              push_ok;

    always_comb begin
        full         = (level_q == LVL_W'(DEPTH));
        pop          = head_valid_q & pop_ready;
        push_ok      = push & (~full | pop);
        wr_ptr_d     = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        level_d      = level_q + LVL_W'(push_ok) - LVL_W'(pop);
        // Head reloads from storage as it stood before this edge's write, giving one cycle of head latency.
        head_valid_d = (level_q - LVL_W'(pop)) != '0;
        head_d       = head_valid_d ? mem_q[rd_ptr_d] : head_q;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
        end
    end

    assign head_valid = head_valid_q;
    assign head_data  = head_q;
    assign level      = level_q;
endmodule

// File: rtl/harris_corner_collector.sv
// rtl/harris_corner_collector.sv - dedups Harris corners, queues them and commits per-frame statistics
module harris_corner_collector
    import harris_corner_collector_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = 10,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              VGA_VS,
    input  logic              corner_detected,
    input  logic [ADDR_W-1:0] addr_corner_x,
    input  logic [ADDR_W-1:0] addr_corner_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_x,
    output logic [ADDR_W-1:0] out_y,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_count,
    output logic              bbox_valid,
    output logic [ADDR_W-1:0] bbox_min_x,
    output logic [ADDR_W-1:0] bbox_min_y,
    output logic [ADDR_W-1:0] bbox_max_x,
    output logic [ADDR_W-1:0] bbox_max_y,
    output logic              frame_overflow,
    output logic              overflow_sticky
);
    state_t              state_q, state_d;
    logic                vs_q;
    logic                cap_valid_q, cap_valid_d;
    logic [ADDR_W-1:0]   cap_x_q, cap_x_d, cap_y_q, cap_y_d;
    logic                have_last_q, have_last_d;
    logic [ADDR_W-1:0]   last_x_q, last_x_d, last_y_q, last_y_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_new;
    logic [ADDR_W-1:0]   min_x_q, min_x_d, min_x_new, min_y_q, min_y_d, min_y_new;
    logic [ADDR_W-1:0]   max_x_q, max_x_d, max_x_new, max_y_q, max_y_d, max_y_new;
    logic                ovf_q, ovf_d, ovf_new;
    logic                sticky_q, sticky_d;
    logic                frame_done_q, frame_done_d;
    logic [CNT_W-1:0]    frame_count_q, frame_count_d;
    logic                bbox_valid_q, bbox_valid_d;
    logic [ADDR_W-1:0]   bmin_x_q, bmin_x_d, bmin_y_q, bmin_y_d;
    logic [ADDR_W-1:0]   bmax_x_q, bmax_x_d, bmax_y_q, bmax_y_d;
    logic                frame_ovf_q, frame_ovf_d;
    logic                vs_fall, pop, commit, is_unique, drop, fifo_full;
    logic [2*ADDR_W-1:0] head_data;

    always_comb begin
        vs_fall   = vs_q & ~VGA_VS;
        pop       = out_valid & out_ready;
        state_d   = state_q;
        if (state_q == WAIT_VS && vs_fall) begin
            state_d = ACTIVE;
        end
        commit    = (state_q == ACTIVE) && vs_fall;
        is_unique = (state_q == ACTIVE) && corner_detected &&
                    (!have_last_q || addr_corner_x != last_x_q || addr_corner_y != last_y_q);
        drop      = cap_valid_q & fifo_full & ~pop;

        cap_valid_d = is_unique;
        cap_x_d     = cap_x_q;
        cap_y_d     = cap_y_q;
        have_last_d = have_last_q;
        last_x_d    = last_x_q;
        last_y_d    = last_y_q;
        cnt_new     = cnt_q;
        min_x_new   = min_x_q;
        min_y_new   = min_y_q;
        max_x_new   = max_x_q;
        max_y_new   = max_y_q;
        if (is_unique) begin
            cap_x_d     = addr_corner_x;
            cap_y_d     = addr_corner_y;
            have_last_d = 1'b1;
            last_x_d    = addr_corner_x;
            last_y_d    = addr_corner_y;
            if (cnt_q != '1) cnt_new = cnt_q + CNT_W'(1);
            if (addr_corner_x < min_x_q) min_x_new = addr_corner_x;
            if (addr_corner_y < min_y_q) min_y_new = addr_corner_y;
            if (addr_corner_x > max_x_q) max_x_new = addr_corner_x;
            if (addr_corner_y > max_y_q) max_y_new = addr_corner_y;
        end
        ovf_new  = ovf_q | drop;
        sticky_d = sticky_q | drop;

        frame_done_d  = commit;
        frame_count_d = frame_count_q;
        bbox_valid_d  = bbox_valid_q;
        bmin_x_d      = bmin_x_q;
        bmin_y_d      = bmin_y_q;
        bmax_x_d      = bmax_x_q;
        bmax_y_d      = bmax_y_q;
        frame_ovf_d   = frame_ovf_q;
        cnt_d         = cnt_new;
        min_x_d       = min_x_new;
        min_y_d       = min_y_new;
        max_x_d       = max_x_new;
        max_y_d       = max_y_new;
        ovf_d         = ovf_new;
        // Commit folds in the corner and drop of the edge cycle itself, then restarts the running frame.
        if (commit) begin
            frame_count_d = cnt_new;
            bbox_valid_d  = (cnt_new != '0);
            frame_ovf_d   = ovf_new;
            if (cnt_new != '0) begin
                bmin_x_d = min_x_new;
                bmin_y_d = min_y_new;
                bmax_x_d = max_x_new;
                bmax_y_d = max_y_new;
            end
            cnt_d       = '0;
            min_x_d     = '1;
            min_y_d     = '1;
            max_x_d     = '0;
            max_y_d     = '0;
            ovf_d       = 1'b0;
            have_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= WAIT_VS;
            vs_q          <= 1'b0;
            cap_valid_q   <= 1'b0;
            cap_x_q       <= '0;
            cap_y_q       <= '0;
            have_last_q   <= 1'b0;
            last_x_q      <= '0;
            last_y_q      <= '0;
            cnt_q         <= '0;
            min_x_q       <= '1;
            min_y_q       <= '1;
            max_x_q       <= '0;
            max_y_q       <= '0;
            ovf_q         <= 1'b0;
            sticky_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            bbox_valid_q  <= 1'b0;
            bmin_x_q      <= '0;
            bmin_y_q      <= '0;
            bmax_x_q      <= '0;
            bmax_y_q      <= '0;
            frame_ovf_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_q          <= VGA_VS;
            cap_valid_q   <= cap_valid_d;
            cap_x_q       <= cap_x_d;
            cap_y_q       <= cap_y_d;
            have_last_q   <= have_last_d;
            last_x_q      <= last_x_d;
            last_y_q      <= last_y_d;
            cnt_q         <= cnt_d;
            min_x_q       <= min_x_d;
            min_y_q       <= min_y_d;
            max_x_q       <= max_x_d;
            max_y_q       <= max_y_d;
            ovf_q         <= ovf_d;
            sticky_q      <= sticky_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            bbox_valid_q  <= bbox_valid_d;
            bmin_x_q      <= bmin_x_d;
            bmin_y_q      <= bmin_y_d;
            bmax_x_q      <= bmax_x_d;
            bmax_y_q      <= bmax_y_d;
            frame_ovf_q   <= frame_ovf_d;
        end
    end

    harris_corner_collector_corner_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (2 * ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push       (cap_valid_q),
        .push_data  ({cap_x_q, cap_y_q}),
        .pop_ready  (out_ready),
        .head_valid (out_valid),
        .head_data  (head_data),
        .level      (fifo_level),
        .full       (fifo_full)
    );

    assign out_x           = head_data[2*ADDR_W-1:ADDR_W];
    assign out_y           = head_data[ADDR_W-1:0];
    assign frame_done      = frame_done_q;
    assign frame_count     = frame_count_q;
    assign bbox_valid      = bbox_valid_q;
    assign bbox_min_x      = bmin_x_q;
    assign bbox_min_y      = bmin_y_q;
    assign bbox_max_x      = bmax_x_q;
    assign bbox_max_y      = bmax_y_q;
    assign frame_overflow  = frame_ovf_q;
    assign overflow_sticky = sticky_q;
endmodule

// File: tb/tb_harris_corner_collector.sv
// tb/tb_harris_corner_collector.sv - self-checking bench for harris_corner_collector
module tb_harris_corner_collector;
    import harris_corner_collector_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = DEF_ADDR_W;
    localparam int CW    = 10;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          VGA_VS = 1'b1;
    logic          corner_detected = 1'b0;
    logic [AW-1:0] ax = '0;
    logic [AW-1:0] ay = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [AW-1:0] out_x, out_y;
    logic [LW-1:0] fifo_level;
    logic          frame_done;
    logic [CW-1:0] frame_count;
    logic          bbox_valid;
    logic [AW-1:0] bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y;
    logic          frame_overflow, overflow_sticky;

    harris_corner_collector #(.DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .VGA_VS          (VGA_VS),
        .corner_detected (corner_detected),
        .addr_corner_x   (ax),
        .addr_corner_y   (ay),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_x           (out_x),
        .out_y           (out_y),
        .fifo_level      (fifo_level),
        .frame_done      (frame_done),
        .frame_count     (frame_count),
        .bbox_valid      (bbox_valid),
        .bbox_min_x      (bbox_min_x),
        .bbox_min_y      (bbox_min_y),
        .bbox_max_x      (bbox_max_x),
        .bbox_max_y      (bbox_max_y),
        .frame_overflow  (frame_overflow),
        .overflow_sticky (overflow_sticky)
    );

    always #5 clk = ~clk;

    int      total = 0;
    int      bad = 0;
    corner_t m_fifo[$];
    corner_t m_frame[$];
    corner_t m_last;
    bit      m_active, m_have_last, m_fovf, m_sticky, m_vs_prev, m_pop_ok, exp_fd;
    int      exp_fc;
    bit      exp_bv, exp_fo;
    int      exp_minx, exp_miny, exp_maxx, exp_maxy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Every accepted beat must match the oldest corner the model expects to be queued.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (m_fifo.size() == 0) begin
                check("beat_unexpected", {1'b1, out_x, out_y}, 32'd0);
            end else begin
                corner_t e;
                e = m_fifo.pop_front();
                check("beat_x", out_x, e.x);
                check("beat_y", out_y, e.y);
            end
        end
    end

    function automatic void model_clear();
        m_fifo.delete();
        m_frame.delete();
        m_active = 0; m_have_last = 0; m_fovf = 0; m_sticky = 0; m_vs_prev = 0; exp_fd = 0;
        exp_fc = 0; exp_bv = 0; exp_fo = 0;
        exp_minx = 0; exp_miny = 0; exp_maxx = 0; exp_maxy = 0;
    endfunction

    function automatic void model_commit();
        int n;
        n = m_frame.size();
        exp_fd = 1;
        exp_fc = (n > 1023) ? 1023 : n;
        exp_bv = (n != 0);
        exp_fo = m_fovf;
        if (n != 0) begin
            exp_minx = m_frame[0].x; exp_maxx = m_frame[0].x;
            exp_miny = m_frame[0].y; exp_maxy = m_frame[0].y;
            foreach (m_frame[i]) begin
                if (m_frame[i].x < exp_minx) exp_minx = m_frame[i].x;
                if (m_frame[i].x > exp_maxx) exp_maxx = m_frame[i].x;
                if (m_frame[i].y < exp_miny) exp_miny = m_frame[i].y;
                if (m_frame[i].y > exp_maxy) exp_maxy = m_frame[i].y;
            end
        end
        m_frame.delete();
        m_have_last = 0;
        m_fovf = 0;
    endfunction

    task automatic cyc();
        bit      vs_fall;
        corner_t c;
        vs_fall = m_vs_prev && !VGA_VS;
        c.x = ax;
        c.y = ay;
        if (m_active && corner_detected && (!m_have_last || c != m_last)) begin
            m_frame.push_back(c);
            m_have_last = 1;
            m_last = c;
            if (m_fifo.size() >= DEPTH && !m_pop_ok) begin
                m_fovf = 1;
                m_sticky = 1;
            end else begin
                m_fifo.push_back(c);
            end
        end
        exp_fd = 0;
        if (vs_fall) begin
            if (m_active) model_commit();
            else m_active = 1;
        end
        m_vs_prev = VGA_VS;
        @(posedge clk);
        #1;
        check("frame_done", frame_done, exp_fd);
        if (exp_fd) begin
            check("frame_count", frame_count, exp_fc);
            check("bbox_valid", bbox_valid, exp_bv);
            check("bbox_min_x", bbox_min_x, exp_minx);
            check("bbox_min_y", bbox_min_y, exp_miny);
            check("bbox_max_x", bbox_max_x, exp_maxx);
            check("bbox_max_y", bbox_max_y, exp_maxy);
            check("frame_overflow", frame_overflow, exp_fo);
        end
    endtask

    task automatic idle(input int n);
        corner_detected = 0;
        repeat (n) cyc();
    endtask

    task automatic corner(input int x, input int y, input int hold);
        corner_detected = 1;
        ax = AW'(x);
        ay = AW'(y);
        repeat (hold) cyc();
        corner_detected = 0;
    endtask

    task automatic vs_edge();
        VGA_VS = 0;
        cyc();
        VGA_VS = 1;
    endtask

    task automatic drain();
        out_ready = 1;
        for (int i = 0; i < 200 && (m_fifo.size() != 0 || out_valid); i++) cyc();
        idle(2);
        check("drain_level", fifo_level, 0);
        check("drain_valid", out_valid, 0);
        check("beats_outstanding", m_fifo.size(), 0);
    endtask

    task automatic do_reset();
        reset = 0;
        corner_detected = 0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_level", fifo_level, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
    endtask

    initial begin
        int n, hold, px, py;
        model_clear();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_bbox_valid", bbox_valid, 0);
        check("rst_bbox_max_x", bbox_max_x, 0);
        check("rst_sticky", overflow_sticky, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;

        // Single corner held 5 cycles, latency and first commit
        out_ready = 1; m_pop_ok = 1;
        idle(2);
        vs_edge();
        idle(2);
        corner_detected = 1; ax = 100; ay = 50;
        cyc(); check("lat_n", out_valid, 0);
        cyc(); check("lat_n1", out_valid, 0);
        cyc(); check("lat_n2", out_valid, 1);
        check("lat_x", out_x, 100);
        cyc(); cyc();
        idle(3);
        check("single_level", fifo_level, 0);
        vs_edge();
        check("single_count", frame_count, 1);
        check("single_bbox", {bbox_valid, bbox_min_x, bbox_min_y}, {1'b1, 10'd100, 10'd50});

        // Bounding box over three corners
        corner(10, 400, 2); idle(1); corner(600, 20, 3); corner(320, 240, 1); idle(4);
        vs_edge();
        check("bb_count", frame_count, 3);
        check("bb_min", {bbox_min_x, bbox_min_y}, {10'd10, 10'd20});
        check("bb_max", {bbox_max_x, bbox_max_y}, {10'd600, 10'd400});

        // Overflow: 20 corners into a stalled FIFO
        out_ready = 0; m_pop_ok = 0;
        for (int i = 0; i < 20; i++) corner(i * 7 + 1, i * 3 + 2, 1);
        idle(3);
        check("ovf_level", fifo_level, 16);
        check("ovf_sticky", overflow_sticky, 1);
        vs_edge();
        check("ovf_count", frame_count, 20);
        check("ovf_frame", frame_overflow, 1);
        drain();
        corner(42, 42, 2); idle(4);
        vs_edge();
        check("ovf_next_frame", frame_overflow, 0);
        check("ovf_sticky_held", overflow_sticky, 1);

        // Full FIFO with a pop in the push cycle
        out_ready = 0;
        for (int i = 0; i < 16; i++) corner(i + 200, i + 100, 1);
        idle(3);
        check("full_level", fifo_level, 16);
        m_pop_ok = 1;
        corner_detected = 1; ax = 500; ay = 300;
        cyc();
        corner_detected = 0; out_ready = 1;
        cyc();
        out_ready = 0;
        check("full_pop_level", fifo_level, 16);
        idle(2);
        vs_edge();
        check("full_pop_count", frame_count, 17);
        check("full_pop_ovf", frame_overflow, 0);
        drain();

        // Corner in the edge cycle belongs to the ending frame
        idle(2);
        corner_detected = 1; ax = 5; ay = 5; VGA_VS = 0;
        cyc();
        check("bound_count_n", frame_count, 1);
        VGA_VS = 1; ax = 6; ay = 6;
        cyc();
        ax = 5; ay = 5;
        cyc();
        idle(3);
        vs_edge();
        check("bound_count_n1", frame_count, 2);
        check("bound_bbox", {bbox_min_x, bbox_max_x}, {10'd5, 10'd6});

        // Randomised frames, one of them empty
        for (int f = 0; f < 5; f++) begin
            n = (f == 2) ? 0 : $urandom_range(3, 10);
            px = 0; py = 0;
            for (int k = 0; k < n; k++) begin
                if (k == 0 || $urandom_range(0, 3) != 0) begin
                    px = $urandom_range(0, VGA_WIDTH - 1);
                    py = $urandom_range(0, VGA_HEIGHT - 1);
                end
                hold = $urandom_range(2, 4);
                corner_detected = 1; ax = AW'(px); ay = AW'(py);
                for (int h = 0; h < hold; h++) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    cyc();
                end
                idle($urandom_range(0, 2));
            end
            idle(2);
            vs_edge();
            drain();
        end

        // Reset with entries queued
        out_ready = 0; m_pop_ok = 0;
        corner(1, 1, 1); corner(2, 2, 1); corner(3, 3, 1); idle(3);
        check("pre_rst_level", fifo_level, 3);
        do_reset();
        out_ready = 1; m_pop_ok = 1;
        corner(7, 7, 2); idle(3);
        check("post_rst_level", fifo_level, 0);
        check("post_rst_valid", out_valid, 0);
        vs_edge();
        corner(8, 8, 2); idle(4);
        vs_edge();
        check("post_rst_count", frame_count, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
